// File: rtl/fba_arbiter_if.sv
// fba_arbiter_if: request/response bundle between NREQ requesters, the shared
// approximate-adder arbiter and the result consumer.
//   req_valid/req_ready : per-requester handshake (NREQ bits each)
//   req_a/req_b         : packed 16-bit operands, requester k at [16k+15:16k]
//   rsp_valid/rsp_ready : result handshake toward the consumer
//   rsp_y/rsp_cout      : approximate sum and upper-byte carry
//   rsp_id              : index of the requester that produced the result
//   op_count            : saturating count of accepted requests
// Modports: master = requesters + consumer side, slave = arbiter side.
interface fba_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [15:0]          rsp_y;
    logic                 rsp_cout;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          op_count;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_cout, rsp_id, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_cout, rsp_id, op_count
    );
endinterface

// File: rtl/fba_arbiter.sv
// fba_arbiter: round-robin arbiter sharing one 16-bit fixed bounding
// approximate adder among NREQ requesters, with a single-entry result register.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : fba_arbiter_if slave modport (request handshakes, operands,
//           result register outputs, accept counter)
// One request is granted per cycle. A new request may be accepted in the same
// cycle the held result drains, so back-to-back results carry no bubble.
module fba_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fba_arbiter_if.slave  bus
);

    logic [IDW-1:0]  ptr_q;
    logic            rsp_valid_q;
    logic [15:0]     rsp_y_q;
    logic            rsp_cout_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [15:0]     op_count_q;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic            can_issue;
    logic            accept;
    logic [IDW-1:0]  ptr_next;
    logic [15:0]     op_a;
    logic [15:0]     op_b;
    logic [16:0]     sum;

    // Fixed bounding approximate adder. Carry-in is tied off in this use, so
    // it is not modelled. Upper byte is exact with no carry from the lower
    // byte; the lower byte ORs the operands and forces every bit at and below
    // the highest generate position to 1 (smear of the generate vector).
    function automatic logic [16:0] fba_add(input logic [15:0] a, input logic [15:0] b);
        logic [7:0] gen;
        logic [7:0] fill;
        logic [8:0] hi;
        gen  = a[7:0] & b[7:0];
        fill = gen | (gen >> 1);
        fill = fill | (fill >> 2);
        fill = fill | (fill >> 4);
        hi   = {1'b0, a[15:8]} + {1'b0, b[15:8]};
        return {hi, (a[7:0] | b[7:0]) | fill};
    endfunction

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin : arb
        int idx;
        idx     = 0;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            idx = (int'(ptr_q) + j) % NREQ;
            if (!gnt_any && bus.req_valid[idx]) begin
                gnt_any     = 1'b1;
                grant[idx]  = 1'b1;
                gnt_idx     = IDW'(idx);
            end
        end
    end

    assign can_issue = ~rsp_valid_q | bus.rsp_ready;
    assign accept    = gnt_any & can_issue & rst_n;
    assign ptr_next  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

    always_comb begin : ready_out
        bus.req_ready = '0;
        if (rst_n && can_issue) begin
            bus.req_ready = grant;
        end
    end

    assign op_a = bus.req_a[16*int'(gnt_idx) +: 16];
    assign op_b = bus.req_b[16*int'(gnt_idx) +: 16];
    assign sum  = fba_add(op_a, op_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            op_count_q  <= '0;
        end else if (accept) begin
            ptr_q       <= ptr_next;
            rsp_valid_q <= 1'b1;
            rsp_y_q     <= sum[15:0];
            rsp_cout_q  <= sum[16];
            rsp_id_q    <= gnt_idx;
            if (op_count_q != 16'hFFFF) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end else if (rsp_valid_q && bus.rsp_ready) begin
            // Drain only; payload keeps its last value.
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: doc/fba_arbiter.md
# fba_arbiter

Round-robin arbiter and result stage sharing one `fba_adder` (16-bit fixed bounding approximate adder) among NREQ requesters.
- Each requester offers an operand pair with a valid/ready handshake.
- One request is granted per cycle and sent through the combinational adder.
- The result is held in a single-entry output register, tagged with the requester index, under consumer backpressure.
- Sits between the CNN MAC lanes and the shared approximate adder.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default 2: width of `rsp_id`; must equal clog2(NREQ).

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset is synchronous and active-low.
- `req_valid`, in, NREQ: per-requester request valid.
- `req_a`, in, 16*NREQ: operand A; requester k uses bits [16k+15:16k].
- `req_b`, in, 16*NREQ: operand B, packed the same way.
- `req_ready`, out, NREQ: per-requester accept; at most one bit high.
- `rsp_valid`, out, 1: result register holds a result.
- `rsp_ready`, in, 1: consumer accepts the result.
- `rsp_y`, out, 16: approximate sum.
- `rsp_cout`, out, 1: carry out of the upper byte.
- `rsp_id`, out, IDW: index of the requester that produced the result.
- `op_count`, out, 16: count of accepted requests, saturating at 0xFFFF.

## Operation

Arbitration:
- Round-robin pointer `ptr` (IDW bits) gives the starting index of the search.
- Grant goes to the first k with `req_valid[k]`=1, searching ptr, ptr+1, … and wrapping modulo NREQ.
- Grant is combinational from `req_valid` and `ptr`.

Issue condition:
- `can_issue = ~rsp_valid | rsp_ready`.
- `req_ready[k] = grant[k] & can_issue`.
- Accept occurs when `req_valid[k] & req_ready[k]`.

On accept:
- `rsp_y` and `rsp_cout` are loaded with `fba_adder(A_k, B_k, cin=0)`.
- `rsp_id` is loaded with k and `rsp_valid` is set to 1.
- `ptr` is set to (k+1) mod NREQ.
- `op_count` increments by 1 unless it is already 0xFFFF.

Without an accept:
- If `rsp_valid & rsp_ready`, `rsp_valid` clears to 0; `rsp_y`, `rsp_cout` and `rsp_id` hold their values.
- Otherwise all state holds.

Adder arithmetic (the bench model must match bit-exactly):
- Upper byte: `{cout, Y[15:8]} = A[15:8] + B[15:8]`. There is no carry from the lower byte, and `cin` is ignored.
- Lower byte:
  - Let i be the highest bit in 7..0 where A[i]&B[i]=1.
  - Y[7:i+1] = A[7:i+1] | B[7:i+1], and Y[i:0] are all 1.
  - If no such i exists, Y[7:0] = A[7:0] | B[7:0].

Requester-side rules:
- Operands are sampled only in the accept cycle.
- A requester must hold `req_valid` and its operands until accepted; the arbiter does not rely on this for correctness.

## Timing

- Latency: a request accepted at edge t gives `rsp_valid`=1 with its result from edge t, i.e. visible in cycle t+1.
- Throughput is one result per cycle while `rsp_ready` stays high.
- Simultaneous drain and accept: with `rsp_valid=1` and `rsp_ready=1`, a new request is accepted in the same cycle and `rsp_valid` stays 1 with the new data. There is no bubble.
- Backpressure: with `rsp_valid=1` and `rsp_ready=0`, all `req_ready` are 0, and `rsp_*` and `ptr` are frozen.
- Reset (`rst_n`=0 at an edge) gives `rsp_valid`=0, `rsp_y`=0, `rsp_cout`=0, `rsp_id`=0, `ptr`=0, `op_count`=0.
  - Reset takes precedence over an accept in the same edge.
  - `req_ready` is forced to 0 while `rst_n`=0.
- Reset mid-operation discards any held result without it being consumed.
- Wrap-around: `ptr` moves from NREQ-1 to 0. `op_count` stays at 0xFFFF once reached.
- Fairness: with all requesters valid continuously and `rsp_ready`=1, grants follow 0,1,…,NREQ-1,0,…
- No requester waits more than NREQ accepts once it is valid.

## Test plan

All scenarios use NREQ=4.

1. **Reset values:** hold `rst_n`=0 for 2 cycles with all `req_valid`=1, then release.
   - During reset: `req_ready`=0, `rsp_valid`=0, `op_count`=0.
   - First accept after release goes to requester 0.
2. **Arithmetic, single requester:** requester 2 with A=0x1234, B=0x00F0 gives `rsp_y`=0x12FF, `rsp_cout`=0, `rsp_id`=2 one cycle later.
   - A=0xFF01, B=0x0102 gives 0x0003, `cout`=1.
   - A=0x0080, B=0x0080 gives 0x00FF, `cout`=0.
3. **Round-robin:** all 4 requesters valid for 8 cycles with `rsp_ready`=1.
   - `rsp_id` sequence is 0,1,2,3,0,1,2,3, `rsp_valid` is high every cycle after the first, and `op_count`=8.
4. **Backpressure:** `rsp_ready`=0 for 5 cycles after the first result.
   - `rsp_valid` stays 1, `rsp_y` and `rsp_id` are unchanged, and `req_ready`=0.
   - When `rsp_ready` returns to 1, the next request is accepted the same cycle and its result appears the following cycle with no gap.
5. **Sparse requests and skip:** only requesters 1 and 3 valid with `ptr`=0.
   - Grants alternate 1,3,1,3, and requesters 0 and 2 never see `req_ready`.
6. **Reset mid-stream and saturation:**
   - Assert `rst_n`=0 while `rsp_valid`=1 and `rsp_ready`=0: `rsp_valid`=0 on the next cycle and `ptr`=0.
   - Force 65536 accepts: `op_count` holds at 0xFFFF.
